// File: rtl/rcu_param.sv
// Receiver control unit for the UART RX path: bit timing, frame sequencing,
// parity/framing checks and buffer handshake for a configurable frame format.
module rcu_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start_bit_detected,
  input  logic serial_in,
  input  logic data_read,
  output logic shift_strobe,
  output logic load_buffer,
  output logic data_ready,
  output logic busy,
  output logic framing_error,
  output logic parity_error,
  output logic overrun_error
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START_CHK = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] LOAD      = 3'd5;

  logic [2:0]    state, state_nxt;
  logic [TW-1:0] timer;
  logic [BW-1:0] bit_cnt;
  logic          par_acc;
  logic          fe_int, pe_int;
  logic          fe_q, pe_q;
  logic          half_hit, bit_hit, data_last, stop_last;
  logic          overrun_new;

  assign half_hit  = (timer == TW'(HALF - 1));
  assign bit_hit   = (timer == TW'(CLKS_PER_BIT - 1));
  assign data_last = (bit_cnt == BW'(DATA_BITS - 1));
  assign stop_last = (bit_cnt == BW'(STOP_BITS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_bit_detected) state_nxt = START_CHK;
      START_CHK: if (half_hit) state_nxt = serial_in ? IDLE : DATA;
      DATA:      if (bit_hit && data_last) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:    if (bit_hit) state_nxt = STOP;
      STOP:      if (bit_hit && stop_last) state_nxt = LOAD;
      LOAD:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Flags become visible during LOAD itself; the registered copies hold them afterwards.
  assign busy          = (state != IDLE);
  assign shift_strobe  = (state == DATA) && bit_hit;
  assign load_buffer   = (state == LOAD) && !fe_int && !pe_int;
  assign framing_error = (state == LOAD) ? fe_int : fe_q;
  assign parity_error  = (state == LOAD) ? pe_int : pe_q;
  assign overrun_new   = load_buffer && data_ready && !data_read;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      par_acc <= 1'b0;
      fe_int  <= 1'b0;
      pe_int  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || bit_hit) timer <= '0;
      else                               timer <= timer + 1'b1;
      case (state)
        START_CHK: if (half_hit && !serial_in) begin
          bit_cnt <= '0;
          par_acc <= 1'b0;
          fe_int  <= 1'b0;
          pe_int  <= 1'b0;
        end
        // bit_cnt is reused to count stop samples, so it restarts on leaving DATA
        DATA: if (bit_hit) begin
          par_acc <= par_acc ^ serial_in;
          bit_cnt <= data_last ? '0 : bit_cnt + 1'b1;
        end
        PARITY: if (bit_hit) pe_int <= par_acc ^ serial_in ^ (PARITY_ODD != 0);
        STOP: if (bit_hit) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (!serial_in) fe_int <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fe_q          <= 1'b0;
      pe_q          <= 1'b0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (state == LOAD) begin
        fe_q <= fe_int;
        pe_q <= pe_int;
      end
      if (load_buffer)    data_ready <= 1'b1;
      else if (data_read) data_ready <= 1'b0;
      if (overrun_new)    overrun_error <= 1'b1;
      else if (data_read) overrun_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rcu_param.sv
// Directed bench for rcu_param: three configurations (8N1, 8O1, 5N2 @16x)
// driven with hand-built serial frames and checked against fixed cycle numbers.
module tb_rcu_param;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] sbd;
  logic [2:0] sin;
  logic [2:0] drd;
  logic [6:0] outv [3];  // {shift, load, ready, busy, ferr, perr, ovr}

  logic s0, l0, r0, b0, f0, p0, o0;
  logic s1, l1, r1, b1, f1, p1, o1;
  logic s2, l2, r2, b2, f2, p2, o2;

  int n_cmp = 0;
  int n_bad = 0;

  int n_strb, first_strb, last_strb, load_cyc, n_load;
  int fe_at, pe_at;
  logic busy_rec [0:255];

  always #5 clk = ~clk;

  rcu_param u_def (
    .clk(clk), .n_rst(rst_n[0]), .start_bit_detected(sbd[0]), .serial_in(sin[0]),
    .data_read(drd[0]), .shift_strobe(s0), .load_buffer(l0), .data_ready(r0),
    .busy(b0), .framing_error(f0), .parity_error(p0), .overrun_error(o0)
  );

  rcu_param #(.PARITY_EN(1), .PARITY_ODD(1)) u_par (
    .clk(clk), .n_rst(rst_n[1]), .start_bit_detected(sbd[1]), .serial_in(sin[1]),
    .data_read(drd[1]), .shift_strobe(s1), .load_buffer(l1), .data_ready(r1),
    .busy(b1), .framing_error(f1), .parity_error(p1), .overrun_error(o1)
  );

  rcu_param #(.DATA_BITS(5), .STOP_BITS(2), .CLKS_PER_BIT(16)) u_52 (
    .clk(clk), .n_rst(rst_n[2]), .start_bit_detected(sbd[2]), .serial_in(sin[2]),
    .data_read(drd[2]), .shift_strobe(s2), .load_buffer(l2), .data_ready(r2),
    .busy(b2), .framing_error(f2), .parity_error(p2), .overrun_error(o2)
  );

  assign outv[0] = {s0, l0, r0, b0, f0, p0, o0};
  assign outv[1] = {s1, l1, r1, b1, f1, p1, o1};
  assign outv[2] = {s2, l2, r2, b2, f2, p2, o2};

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Line bit j (j=0 is the start bit) is held for cycles j*cpb .. (j+1)*cpb-1.
  function automatic logic [31:0] mk_frame(input logic [8:0] d, input int nd, input int pen,
                                           input logic pbit, input logic [1:0] stopv,
                                           input int nstop);
    logic [31:0] f;
    int idx;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < nd; i++) f[1+i] = d[i];
    idx = 1 + nd;
    if (pen != 0) begin
      f[idx] = pbit;
      idx++;
    end
    for (int s = 0; s < nstop; s++) f[idx+s] = stopv[s];
    return f;
  endfunction

  // Entered and left at posedge+1; cycle 0 carries the start_bit_detected pulse.
  task automatic run_frame(input int k, input int cpb, input logic [31:0] fr,
                           input int ncyc, input int flag_cyc);
    int j;
    n_strb = 0; first_strb = -1; last_strb = -1; load_cyc = -1; n_load = 0;
    fe_at = -1; pe_at = -1;
    for (int c = 0; c < ncyc; c++) begin
      j = c / cpb;
      sbd[k] = (c == 0);
      sin[k] = (j < 32) ? fr[j] : 1'b1;
      @(negedge clk);
      if (c < 256) busy_rec[c] = outv[k][3];
      if (outv[k][6]) begin
        n_strb++;
        if (first_strb < 0) first_strb = c;
        last_strb = c;
      end
      if (outv[k][5]) begin
        n_load++;
        load_cyc = c;
      end
      if (c == flag_cyc) begin
        fe_at = int'(outv[k][2]);
        pe_at = int'(outv[k][1]);
      end
      @(posedge clk);
      #1;
    end
    sbd[k] = 1'b0;
    sin[k] = 1'b1;
  endtask

  task automatic pulse_read(input int k);
    drd[k] = 1'b1;
    @(posedge clk);
    #1;
    drd[k] = 1'b0;
  endtask

  initial begin
    rst_n = '0; sbd = '0; sin = '1; drd = '0;
    for (int i = 0; i < 256; i++) busy_rec[i] = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs_def", int'(outv[0]), 0);
    chk("reset_outs_par", int'(outv[1]), 0);
    chk("reset_outs_52",  int'(outv[2]), 0);
    @(posedge clk); #1;
    rst_n = '1;
    @(posedge clk); #1;

    // 8N1 frame 0x55
    run_frame(0, 10, mk_frame(9'h055, 8, 0, 1'b0, 2'b11, 1), 99, 96);
    chk("t1_strobes", n_strb, 8);
    chk("t1_first_strobe", first_strb, 15);
    chk("t1_last_strobe", last_strb, 85);
    chk("t1_load_cycle", load_cyc, 96);
    chk("t1_load_count", n_load, 1);
    chk("t1_ferr", fe_at, 0);
    chk("t1_perr", pe_at, 0);
    chk("t1_ready", int'(outv[0][4]), 1);
    chk("t1_ovr", int'(outv[0][0]), 0);
    pulse_read(0);
    chk("t1_ready_after_read", int'(outv[0][4]), 0);

    // false start: line already high when the start bit is re-checked
    run_frame(0, 10, 32'hFFFF_FFFF, 12, 5);
    chk("t2_busy_c5", int'(busy_rec[5]), 1);
    chk("t2_busy_c6", int'(busy_rec[6]), 0);
    chk("t2_strobes", n_strb, 0);
    chk("t2_loads", n_load, 0);
    chk("t2_ferr", int'(outv[0][2]), 0);
    chk("t2_ready", int'(outv[0][4]), 0);

    // stop sample low -> framing error, no load
    run_frame(0, 10, mk_frame(9'h0A3, 8, 0, 1'b0, 2'b00, 1), 99, 96);
    chk("t3_ferr_c96", fe_at, 1);
    chk("t3_loads", n_load, 0);
    chk("t3_ferr_held", int'(outv[0][2]), 1);
    chk("t3_ready", int'(outv[0][4]), 0);
    run_frame(0, 10, mk_frame(9'h0A3, 8, 0, 1'b0, 2'b11, 1), 99, 96);
    chk("t3b_ferr_c96", fe_at, 0);
    chk("t3b_load_cycle", load_cyc, 96);
    chk("t3b_ferr_after", int'(outv[0][2]), 0);

    // second unread frame -> overrun
    run_frame(0, 10, mk_frame(9'h0F0, 8, 0, 1'b0, 2'b11, 1), 99, 96);
    chk("t5_load_cycle", load_cyc, 96);
    chk("t5_ovr", int'(outv[0][0]), 1);
    chk("t5_ready", int'(outv[0][4]), 1);
    pulse_read(0);
    chk("t5_ready_cleared", int'(outv[0][4]), 0);
    chk("t5_ovr_cleared", int'(outv[0][0]), 0);

    // odd parity, 0x03 has two ones: parity bit must be 1
    run_frame(1, 10, mk_frame(9'h003, 8, 1, 1'b0, 2'b11, 1), 109, 106);
    chk("t4_perr", pe_at, 1);
    chk("t4_loads", n_load, 0);
    chk("t4_perr_held", int'(outv[1][1]), 1);
    run_frame(1, 10, mk_frame(9'h003, 8, 1, 1'b1, 2'b11, 1), 109, 106);
    chk("t4b_load_cycle", load_cyc, 106);
    chk("t4b_perr", pe_at, 0);
    chk("t4b_ready", int'(outv[1][4]), 1);

    // 5N2 at 16 clocks/bit with a reset mid-DATA
    run_frame(2, 16, mk_frame(9'h015, 5, 0, 1'b0, 2'b11, 2), 124, 121);
    chk("t6_first_load", load_cyc, 121);
    chk("t6_strobes", n_strb, 5);
    run_frame(2, 16, mk_frame(9'h00A, 5, 0, 1'b0, 2'b11, 2), 50, 0);
    chk("t6_busy_mid", int'(outv[2][3]), 1);
    rst_n[2] = 1'b0;
    #1;
    chk("t6_reset_outs", int'(outv[2]), 0);
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    @(posedge clk); #1;
    chk("t6_after_reset", int'(outv[2]), 0);
    run_frame(2, 16, mk_frame(9'h01C, 5, 0, 1'b0, 2'b11, 2), 124, 121);
    chk("t6_load_cycle", load_cyc, 121);
    chk("t6_load_count", n_load, 1);
    chk("t6_ready", int'(outv[2][4]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
